// File: rtl/tl_rx_vc_scheduler.sv
// Receive-side VC scheduler: picks a P/NP/CPL TLP, pops its header, then streams its payload beats.
// Optional macro TL_RX_VC_SCHED_CPL_PRIO_EN gives completions strict priority over P/NP.
module tl_rx_vc_scheduler #(
  parameter int unsigned BEAT_CNT_WIDTH = 8,
  parameter int unsigned FLAGS_WIDTH    = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [FLAGS_WIDTH-1:0]    i_vc_r_empty_flags,
  input  logic [BEAT_CNT_WIDTH-1:0] i_p_beats,
  input  logic [BEAT_CNT_WIDTH-1:0] i_np_beats,
  input  logic [BEAT_CNT_WIDTH-1:0] i_cpl_beats,
  input  logic                      i_sink_ready,
  output logic                      o_p_hdr_rd,
  output logic                      o_p_data_rd,
  output logic                      o_np_hdr_rd,
  output logic                      o_np_data_rd,
  output logic                      o_cpl_hdr_rd,
  output logic                      o_cpl_data_rd,
  output logic [2:0]                o_grant,
  output logic                      o_hdr_valid,
  output logic                      o_data_valid,
  output logic                      o_last,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] CLS_P   = 2'd0;
  localparam logic [1:0] CLS_NP  = 2'd1;
  localparam logic [1:0] CLS_CPL = 2'd2;

  // One-hot pick over {cpl, np, p}, searching from the class after 'last'.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] gnt;
    gnt = 3'b000;
    case (last)
      CLS_P: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      CLS_NP: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
    return gnt;
  endfunction

  function automatic logic [1:0] onehot_to_cls(input logic [2:0] g);
    logic [1:0] cls;
    if (g[2])      cls = CLS_CPL;
    else if (g[1]) cls = CLS_NP;
    else           cls = CLS_P;
    return cls;
  endfunction

  state_e                    state_q, state_d;
  logic [2:0]                grant_q, grant_d;
  logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]                last_cls_q, last_cls_d;

  logic [2:0]                hdr_empty, data_empty, elig, winner;
  logic [BEAT_CNT_WIDTH-1:0] sel_beats;
  logic                      hdr_acc, data_vld, data_acc, last_c;

  assign hdr_empty  = {i_vc_r_empty_flags[1], i_vc_r_empty_flags[3], i_vc_r_empty_flags[5]};
  assign data_empty = {i_vc_r_empty_flags[0], i_vc_r_empty_flags[2], i_vc_r_empty_flags[4]};
  assign elig       = ~hdr_empty;

`ifdef TL_RX_VC_SCHED_CPL_PRIO_EN
  assign winner = elig[2] ? 3'b100 : rr_pick({1'b0, elig[1:0]}, last_cls_q);
`else
  assign winner = rr_pick(elig, last_cls_q);
`endif

  always_comb begin
    sel_beats = i_cpl_beats;
    if (grant_q[0])      sel_beats = i_p_beats;
    else if (grant_q[1]) sel_beats = i_np_beats;
  end

  assign hdr_acc  = (state_q == HDR) & i_sink_ready;
  assign data_vld = (state_q == DATA) & ~|(grant_q & data_empty);
  assign data_acc = data_vld & i_sink_ready;
  assign last_c   = (hdr_acc & (sel_beats == '0)) |
                    (data_acc & (cnt_q == BEAT_CNT_WIDTH'(1)));

  // Next-state: grant in IDLE, capture beat count at header accept, count beats down in DATA.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    last_cls_d = last_cls_q;
    case (state_q)
      IDLE: begin
        if (|winner) begin
          grant_d = winner;
          state_d = HDR;
        end
      end
      HDR: begin
        if (hdr_acc) begin
          cnt_d   = sel_beats;
          state_d = DATA;
        end
      end
      DATA: begin
        if (data_acc) cnt_d = cnt_q - BEAT_CNT_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
    if (last_c) begin
      state_d = IDLE;
      grant_d = 3'b000;
      cnt_d   = '0;
`ifdef TL_RX_VC_SCHED_CPL_PRIO_EN
      // CPL wins never move the pointer, so P/NP alternate among themselves.
      if (!grant_q[2]) last_cls_d = onehot_to_cls(grant_q);
`else
      last_cls_d = onehot_to_cls(grant_q);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      grant_q    <= 3'b000;
      cnt_q      <= '0;
      last_cls_q <= CLS_CPL;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      last_cls_q <= last_cls_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_hdr_valid   = (state_q == HDR);
  assign o_data_valid  = data_vld;
  assign o_last        = last_c;
  assign o_busy        = (state_q != IDLE);
  assign o_p_hdr_rd    = hdr_acc  & grant_q[0];
  assign o_np_hdr_rd   = hdr_acc  & grant_q[1];
  assign o_cpl_hdr_rd  = hdr_acc  & grant_q[2];
  assign o_p_data_rd   = data_acc & grant_q[0];
  assign o_np_data_rd  = data_acc & grant_q[1];
  assign o_cpl_data_rd = data_acc & grant_q[2];

endmodule

// File: tb/tb_tl_rx_vc_scheduler.sv
// Bench for tl_rx_vc_scheduler: VC FIFO model plus transaction-level reference, directed and random phases.
module tb_tl_rx_vc_scheduler;

  localparam int unsigned BW = 8;
  localparam int unsigned FW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] i_vc_r_empty_flags;
  logic [BW-1:0] i_p_beats, i_np_beats, i_cpl_beats;
  logic          i_sink_ready;
  logic          o_p_hdr_rd, o_p_data_rd, o_np_hdr_rd, o_np_data_rd, o_cpl_hdr_rd, o_cpl_data_rd;
  logic [2:0]    o_grant;
  logic          o_hdr_valid, o_data_valid, o_last, o_busy;

  always #5 clk = ~clk;

  tl_rx_vc_scheduler #(.BEAT_CNT_WIDTH(BW), .FLAGS_WIDTH(FW)) dut (
    .i_clk(clk), .i_rst(rst), .i_vc_r_empty_flags(i_vc_r_empty_flags),
    .i_p_beats(i_p_beats), .i_np_beats(i_np_beats), .i_cpl_beats(i_cpl_beats),
    .i_sink_ready(i_sink_ready),
    .o_p_hdr_rd(o_p_hdr_rd), .o_p_data_rd(o_p_data_rd),
    .o_np_hdr_rd(o_np_hdr_rd), .o_np_data_rd(o_np_data_rd),
    .o_cpl_hdr_rd(o_cpl_hdr_rd), .o_cpl_data_rd(o_cpl_data_rd),
    .o_grant(o_grant), .o_hdr_valid(o_hdr_valid), .o_data_valid(o_data_valid),
    .o_last(o_last), .o_busy(o_busy)
  );

  int checks = 0;
  int failures = 0;

  // VC buffer model: per class (0=P,1=NP,2=CPL) header queue of beat counts and data beat counts.
  int tlp_q [3][$];
  int data_cnt [3];
  int data_pend [3];

  // Reference: owner class, phase (0 idle, 1 header, 2 data), beats left, round-robin history.
  int m_cls, m_ph, m_rem, m_last, m_last_pnp;
  int rdy_mode;
  bit rand_push;
  int n_hdr_rd [3];
  int n_data_rd [3];
  int n_last;
  int glog [$];
  logic [2:0] prev_grant;

  function automatic int pick(input bit [2:0] e);
`ifdef TL_RX_VC_SCHED_CPL_PRIO_EN
    if (e[2]) return 2;
    if (e[0] && e[1]) return (m_last_pnp == 0) ? 1 : 0;
    if (e[0]) return 0;
    if (e[1]) return 1;
    return -1;
`else
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (e[c]) return c;
    end
    return -1;
`endif
  endfunction

  task automatic model_reset();
    m_cls = -1; m_ph = 0; m_rem = 0; m_last = 2; m_last_pnp = 1;
    prev_grant = 3'b000;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_tlp(input int c, input int b, input int now, input bit trickle_rest);
    tlp_q[c].push_back(b);
    data_cnt[c] += now;
    if (trickle_rest) data_pend[c] += b - now;
  endtask

  function automatic logic [12:0] obs_vec();
    return {o_grant, o_hdr_valid, o_data_valid, o_last, o_busy,
            o_p_hdr_rd, o_p_data_rd, o_np_hdr_rd, o_np_data_rd, o_cpl_hdr_rd, o_cpl_data_rd};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    assert (obs_vec() === 13'b0) else begin
      failures++;
      $error("FAIL reset_outputs observed=%b expected=%b", obs_vec(), 13'b0);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: drive inputs from the buffer model, compare every output, then advance the model.
  task automatic cycle();
    logic [12:0] exp_v, obs_v;
    logic [2:0]  g, rd_h, rd_d;
    bit [2:0]    elig;
    logic        hv, dv, ah, ad, lst, rdy;
    int          hb, c, w;
    bit          was_idle;
    @(negedge clk);
    i_vc_r_empty_flags = {tlp_q[0].size() == 0, data_cnt[0] == 0,
                          tlp_q[1].size() == 0, data_cnt[1] == 0,
                          tlp_q[2].size() == 0, data_cnt[2] == 0};
    i_p_beats   = (tlp_q[0].size() > 0) ? BW'(tlp_q[0][0]) : BW'($urandom);
    i_np_beats  = (tlp_q[1].size() > 0) ? BW'(tlp_q[1][0]) : BW'($urandom);
    i_cpl_beats = (tlp_q[2].size() > 0) ? BW'(tlp_q[2][0]) : BW'($urandom);
    case (rdy_mode)
      0:       rdy = 1'b1;
      2:       rdy = 1'b0;
      default: rdy = ($urandom_range(3) != 0);
    endcase
    i_sink_ready = rdy;
    #1;
    c = m_cls; hb = 0; g = 3'b000; dv = 1'b0;
    if (m_ph != 0) g = 3'(1 << c);
    if (m_ph == 1) hb = tlp_q[c][0];
    if (m_ph == 2) dv = (data_cnt[c] > 0);
    hv   = (m_ph == 1);
    ah   = hv && rdy;
    ad   = dv && rdy;
    lst  = (ah && hb == 0) || (ad && m_rem == 1);
    rd_h = ah ? g : 3'b000;
    rd_d = ad ? g : 3'b000;
    exp_v = {g, hv, dv, lst, (m_ph != 0), rd_h[0], rd_d[0], rd_h[1], rd_d[1], rd_h[2], rd_d[2]};
    obs_v = obs_vec();
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL cycle_outputs t=%0t observed=%b expected=%b (grant,hv,dv,last,busy,p_h,p_d,np_h,np_d,cpl_h,cpl_d)",
             $time, obs_v, exp_v);
    end
    if (prev_grant == 3'b000 && o_grant != 3'b000)
      glog.push_back(o_grant == 3'b001 ? 0 : o_grant == 3'b010 ? 1 : o_grant == 3'b100 ? 2 : 9);
    prev_grant = o_grant;
    n_hdr_rd[0]  += int'(o_p_hdr_rd);   n_data_rd[0] += int'(o_p_data_rd);
    n_hdr_rd[1]  += int'(o_np_hdr_rd);  n_data_rd[1] += int'(o_np_data_rd);
    n_hdr_rd[2]  += int'(o_cpl_hdr_rd); n_data_rd[2] += int'(o_cpl_data_rd);
    n_last       += int'(o_last);
    was_idle = (m_ph == 0);
    if (ah) begin
      void'(tlp_q[c].pop_front());
      if (hb != 0) begin m_ph = 2; m_rem = hb; end
    end else if (ad) begin
      data_cnt[c]--;
      m_rem--;
    end else if (was_idle) begin
      elig = {tlp_q[2].size() > 0, tlp_q[1].size() > 0, tlp_q[0].size() > 0};
      w = pick(elig);
      if (w >= 0) begin m_cls = w; m_ph = 1; end
    end
    if (lst) begin
      m_last = c;
      if (c != 2) m_last_pnp = c;
      m_ph = 0; m_cls = -1; m_rem = 0;
    end
    for (int k = 0; k < 3; k++) begin
      if (data_pend[k] > 0 && $urandom_range(1) == 1) begin
        data_pend[k]--; data_cnt[k]++;
      end
      if (rand_push && $urandom_range(23) == 0) begin
        int b;
        b = $urandom_range(5);
        push_tlp(k, b, $urandom_range(b), 1'b1);
      end
    end
  endtask

  function automatic bit all_done();
    return (m_ph == 0) && tlp_q[0].size() == 0 && tlp_q[1].size() == 0 && tlp_q[2].size() == 0;
  endfunction

  task automatic drain(input int maxc, input string tag);
    int n;
    n = 0;
    while (!all_done() && n < maxc) begin cycle(); n++; end
    chk(tag, int'(all_done()), 1);
  endtask

  initial begin
    int h0, d0, l0, n, mark;
    int exp_order [6];
    rst = 1'b1;
    i_vc_r_empty_flags = '1;
    i_p_beats = '0; i_np_beats = '0; i_cpl_beats = '0;
    i_sink_ready = 1'b0;
    rand_push = 1'b0;
    rdy_mode = 0;
    n_last = 0;
    for (int k = 0; k < 3; k++) begin
      data_cnt[k] = 0; data_pend[k] = 0; n_hdr_rd[k] = 0; n_data_rd[k] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    repeat (2) cycle();

    // Single P header, no payload.
    h0 = n_hdr_rd[0]; l0 = n_last; mark = glog.size();
    push_tlp(0, 0, 0, 1'b0);
    repeat (4) cycle();
    chk("p_nopayload_hdr_rd", n_hdr_rd[0] - h0, 1);
    chk("p_nopayload_last", n_last - l0, 1);
    chk("p_nopayload_grant", glog[mark], 0);

    // NP with three beats, all data present.
    h0 = n_hdr_rd[1]; d0 = n_data_rd[1];
    push_tlp(1, 3, 3, 1'b0);
    drain(20, "np3_drain");
    cycle();
    chk("np3_hdr_rd", n_hdr_rd[1] - h0, 1);
    chk("np3_data_rd", n_data_rd[1] - d0, 3);
    chk("np3_busy_after", int'(o_busy), 0);

    // P with four beats, data runs dry after two for five cycles.
    d0 = n_data_rd[0];
    push_tlp(0, 4, 2, 1'b0);
    n = 0;
    while (n_data_rd[0] - d0 < 2 && n < 20) begin cycle(); n++; end
    chk("p4_first_two", n_data_rd[0] - d0, 2);
    repeat (5) begin
      cycle();
      chk("p4_gap_data_valid", int'(o_data_valid), 0);
    end
    chk("p4_gap_no_strobes", n_data_rd[0] - d0, 2);
    data_cnt[0] += 2;
    drain(20, "p4_drain");
    chk("p4_total_beats", n_data_rd[0] - d0, 4);

    // Ready held low in HDR; beats input changes once the header is accepted.
    h0 = n_hdr_rd[0]; d0 = n_data_rd[0]; l0 = n_last;
    push_tlp(0, 2, 2, 1'b0);
    rdy_mode = 2;
    n = 0;
    while (m_ph != 1 && n < 10) begin cycle(); n++; end
    chk("stall_in_hdr", m_ph, 1);
    repeat (4) cycle();
    chk("stall_no_hdr_rd", n_hdr_rd[0] - h0, 0);
    push_tlp(0, 7, 0, 1'b1);
    rdy_mode = 0;
    n = 0;
    while (n_last == l0 && n < 20) begin cycle(); n++; end
    chk("stall_hdr_rd", n_hdr_rd[0] - h0, 1);
    chk("beats_change_ignored", n_data_rd[0] - d0, 2);
    drain(60, "stall_drain");

    // Maximum beat count.
    d0 = n_data_rd[0];
    push_tlp(0, 255, 255, 1'b0);
    drain(400, "max_beats_drain");
    chk("max_beats", n_data_rd[0] - d0, 255);

    // Reset mid-payload; P must be searched first afterwards.
    push_tlp(0, 0, 0, 1'b0);
    drain(10, "pre_abort_drain");
    push_tlp(0, 4, 4, 1'b0);
    n = 0;
    while (!(m_ph == 2 && m_rem == 2) && n < 20) begin cycle(); n++; end
    chk("abort_reached_cnt2", m_rem, 2);
    do_reset();
    mark = glog.size();
    push_tlp(1, 0, 0, 1'b0);
    push_tlp(0, 0, 0, 1'b0);
    drain(20, "post_abort_drain");
    chk("post_abort_first_grant", glog[mark], 0);

    // All classes continuously eligible, no payloads.
    do_reset();
    mark = glog.size();
    for (int i = 0; i < 6; i++) for (int k = 0; k < 3; k++) push_tlp(k, 0, 0, 1'b0);
    drain(100, "rr_drain");
`ifdef TL_RX_VC_SCHED_CPL_PRIO_EN
    exp_order = '{2, 2, 2, 2, 2, 2};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order_%0d", i), glog[mark + i], exp_order[i]);

    // Random traffic with random back-pressure and one reset in the middle.
    rand_push = 1'b1;
    rdy_mode = 1;
    repeat (300) cycle();
    do_reset();
    repeat (300) cycle();
    rand_push = 1'b0;
    drain(3000, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
